// File: rtl/spi_flash_pkg.sv
// rtl/spi_flash_pkg.sv - shared opcodes, op encodings, sizes and state types for the flash sequencer
//
// Contents:
//   CMD_*        SPI flash command opcodes
//   OP_*         host op_code encodings
//   FRAME_W      width of the spi_cmd frame bus (260 bytes)
//   MAX_PAGE     largest PROGRAM byte count
//   seq_state_t  sequencer states
//   slot_phase_t command slot handshake phases
//   op_cmd()     opcode sent in the main frame for a host op
package spi_flash_pkg;

    localparam int FRAME_W  = 2080;
    localparam int MAX_PAGE = 256;

    localparam logic [7:0] CMD_WREN = 8'h06;
    localparam logic [7:0] CMD_RDSR = 8'h05;
    localparam logic [7:0] CMD_PP   = 8'h02;
    localparam logic [7:0] CMD_SE   = 8'hD8;

    localparam logic [1:0] OP_ERASE       = 2'd0;
    localparam logic [1:0] OP_PROGRAM     = 2'd1;
    localparam logic [1:0] OP_READ_STATUS = 2'd2;
    localparam logic [1:0] OP_ILLEGAL     = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WREN,
        ST_MAIN,
        ST_GAP,
        ST_POLL,
        ST_FINISH
    } seq_state_t;

    typedef enum logic [1:0] {
        PH_ISSUE,
        PH_START,
        PH_END
    } slot_phase_t;

    function automatic logic [7:0] op_cmd(input logic [1:0] code);
        case (code)
            OP_ERASE:       return CMD_SE;
            OP_PROGRAM:     return CMD_PP;
            OP_READ_STATUS: return CMD_RDSR;
            default:        return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/spi_flash_seq_if.sv
// rtl/spi_flash_seq_if.sv - host-side operation, page-byte and completion signals of the flash sequencer
//
// Signals:
//   op_valid/op_ready       operation request handshake
//   op_code/op_addr/op_len  operation, byte address, PROGRAM byte count
//   quad                    IO mode for the whole operation
//   wr_valid/wr_ready       page byte stream handshake, wr_data first byte first
//   done/err/status         completion pulse, error flag, last status register
// Modports:
//   master  host / control logic side
//   slave   sequencer side
interface spi_flash_seq_if;
    import spi_flash_pkg::*;

    logic       op_valid;
    logic       op_ready;
    logic [1:0] op_code;
    logic [23:0] op_addr;
    logic [8:0] op_len;
    logic       quad;
    logic       wr_valid;
    logic       wr_ready;
    logic [7:0] wr_data;
    logic       done;
    logic       err;
    logic [7:0] status;

    modport master (
        output op_valid, op_code, op_addr, op_len, quad, wr_valid, wr_data,
        input  op_ready, wr_ready, done, err, status
    );

    modport slave (
        input  op_valid, op_code, op_addr, op_len, quad, wr_valid, wr_data,
        output op_ready, wr_ready, done, err, status
    );

endinterface

// File: rtl/spi_cmd_issue.sv
// rtl/spi_cmd_issue.sv - one spi_cmd command slot: ISSUE, START, END handshake with strobes
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   i_go           a command slot is active in the sequencer
//   i_spi_busy     busy from spi_cmd
//   o_spi_trigger  trigger to spi_cmd, only while busy is low
//   o_start        spi_cmd has taken the command (busy seen high)
//   o_complete     command finished (busy back low); read data is valid this cycle
module spi_cmd_issue
    import spi_flash_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_go,
    input  logic i_spi_busy,
    output logic o_spi_trigger,
    output logic o_start,
    output logic o_complete
);

    slot_phase_t r_phase;

    // Trigger is gated by busy, so it stalls while spi_cmd is in reset, and
    // it cannot repeat: the phase leaves ISSUE on the same edge it fires.
    assign o_spi_trigger = i_go && (r_phase == PH_ISSUE) && !i_spi_busy;
    assign o_start       = (r_phase == PH_START) && i_spi_busy;
    assign o_complete    = i_go && (r_phase == PH_END) && !i_spi_busy;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase <= PH_ISSUE;
        end else begin
            case (r_phase)
                PH_ISSUE: if (o_spi_trigger) r_phase <= PH_START;
                PH_START: if (i_spi_busy)    r_phase <= PH_END;
                PH_END:   if (!i_spi_busy)   r_phase <= PH_ISSUE;
                default:                     r_phase <= PH_ISSUE;
            endcase
        end
    end

endmodule

// File: rtl/spi_flash_seq.sv
// rtl/spi_flash_seq.sv - turns host flash ops (erase, program, read status) into spi_cmd command series
//
// Ports:
//   clk, reset            clock, synchronous active-high reset (shared with spi_cmd)
//   host                  op request, page byte stream and completion (spi_flash_seq_if.slave)
//   spi_trigger           trigger to spi_cmd
//   spi_busy              busy from spi_cmd
//   spi_data_in_count     frame length in bytes
//   spi_data_out_count    1 = read one byte after the frame
//   spi_data_in           frame, right-aligned, first byte highest
//   spi_data_out          read byte from spi_cmd
//   spi_quad              IO mode latched at accept
// Parameters:
//   POLL_GAP              idle clocks before each RDSR poll (>= 1)
//   POLL_MAX              RDSR polls allowed after a write before timeout
module spi_flash_seq
    import spi_flash_pkg::*;
#(
    parameter int POLL_GAP = 64,
    parameter int POLL_MAX = 65535
) (
    input  logic               clk,
    input  logic               reset,
    spi_flash_seq_if.slave     host,
    output logic               spi_trigger,
    input  logic               spi_busy,
    output logic [8:0]         spi_data_in_count,
    output logic               spi_data_out_count,
    output logic [FRAME_W-1:0] spi_data_in,
    input  logic [7:0]         spi_data_out,
    output logic               spi_quad
);

    localparam int                GAP_W       = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;
    localparam logic [GAP_W-1:0]  GAP_LAST    = GAP_W'(POLL_GAP - 1);
    localparam logic [16:0]       POLL_LIMIT  = 17'(POLL_MAX);

    seq_state_t         r_state;
    logic [FRAME_W-1:0] r_frame;
    logic [1:0]         r_op;
    logic [8:0]         r_len;
    logic [8:0]         r_byte_cnt;
    logic [15:0]        r_poll_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               r_quad;
    logic               r_err;
    logic               r_done;
    logic [7:0]         r_status;
    logic [8:0]         r_in_count;
    logic               r_out_count;

    logic               w_slot_go;
    logic               w_slot_start;
    logic               w_slot_complete;
    logic [16:0]        w_polls_done;

    assign w_slot_go    = (r_state == ST_WREN) || (r_state == ST_MAIN) || (r_state == ST_POLL);
    assign w_polls_done = {1'b0, r_poll_cnt} + 17'd1;

    spi_cmd_issue u_issue (
        .clk           (clk),
        .reset         (reset),
        .i_go          (w_slot_go),
        .i_spi_busy    (spi_busy),
        .o_spi_trigger (spi_trigger),
        .o_start       (w_slot_start),
        .o_complete    (w_slot_complete)
    );

    assign host.op_ready      = (r_state == ST_IDLE);
    assign host.wr_ready      = (r_state == ST_LOAD);
    assign host.done          = r_done;
    assign host.err           = r_err;
    assign host.status        = r_status;
    assign spi_data_in_count  = r_in_count;
    assign spi_data_out_count = r_out_count;
    assign spi_quad           = r_quad;

    // WREN and RDSR are single-opcode frames, so they bypass the frame
    // register and leave the loaded erase/program frame untouched.
    always_comb begin
        spi_data_in = r_frame;
        case (r_state)
            ST_WREN: spi_data_in = {{(FRAME_W-8){1'b0}}, CMD_WREN};
            ST_POLL: spi_data_in = {{(FRAME_W-8){1'b0}}, CMD_RDSR};
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_frame     <= '0;
            r_op        <= OP_ERASE;
            r_len       <= '0;
            r_byte_cnt  <= '0;
            r_poll_cnt  <= '0;
            r_gap_cnt   <= '0;
            r_quad      <= 1'b0;
            r_err       <= 1'b0;
            r_done      <= 1'b0;
            r_status    <= 8'h00;
            r_in_count  <= '0;
            r_out_count <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // Every command start re-arms the gap counter, so each GAP visit
            // begins counting from zero.
            if (w_slot_start) r_gap_cnt <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (host.op_valid) begin
                        r_quad     <= host.quad;
                        r_err      <= 1'b0;
                        r_frame    <= {{(FRAME_W-32){1'b0}}, op_cmd(host.op_code), host.op_addr};
                        r_op       <= host.op_code;
                        r_len      <= host.op_len;
                        r_byte_cnt <= '0;
                        case (host.op_code)
                            OP_ERASE: begin
                                r_state     <= ST_WREN;
                                r_in_count  <= 9'd1;
                                r_out_count <= 1'b0;
                            end
                            OP_PROGRAM: begin
                                if (host.op_len == 9'd0 || host.op_len > 9'(MAX_PAGE)) begin
                                    r_state <= ST_FINISH;
                                    r_err   <= 1'b1;
                                end else begin
                                    r_state <= ST_LOAD;
                                end
                            end
                            OP_READ_STATUS: begin
                                r_state     <= ST_POLL;
                                r_in_count  <= 9'd1;
                                r_out_count <= 1'b1;
                            end
                            default: begin
                                r_state <= ST_FINISH;
                                r_err   <= 1'b1;
                            end
                        endcase
                    end
                end

                ST_LOAD: begin
                    if (host.wr_valid) begin
                        // Shift left so the first page byte ends up just below
                        // the address and the last byte lands in [7:0].
                        r_frame    <= {r_frame[FRAME_W-9:0], host.wr_data};
                        r_byte_cnt <= r_byte_cnt + 9'd1;
                        if (r_byte_cnt == r_len - 9'd1) begin
                            r_state     <= ST_WREN;
                            r_in_count  <= 9'd1;
                            r_out_count <= 1'b0;
                        end
                    end
                end

                ST_WREN: begin
                    if (w_slot_complete) begin
                        r_state     <= ST_MAIN;
                        r_in_count  <= (r_op == OP_PROGRAM) ? 9'd4 + r_len : 9'd4;
                        r_out_count <= 1'b0;
                    end
                end

                ST_MAIN: begin
                    if (w_slot_complete) begin
                        r_state    <= ST_GAP;
                        r_poll_cnt <= '0;
                    end
                end

                ST_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state     <= ST_POLL;
                        r_in_count  <= 9'd1;
                        r_out_count <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end

                ST_POLL: begin
                    if (w_slot_complete) begin
                        r_status   <= spi_data_out;
                        r_poll_cnt <= r_poll_cnt + 16'd1;
                        if (r_op == OP_READ_STATUS || !spi_data_out[0]) begin
                            r_state <= ST_FINISH;
                        end else if (w_polls_done >= POLL_LIMIT) begin
                            r_state <= ST_FINISH;
                            r_err   <= 1'b1;
                        end else begin
                            r_state <= ST_GAP;
                        end
                    end
                end

                ST_FINISH: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_flash_seq.md
# spi_flash_seq

Operation sequencer in front of the `spi_cmd` engine; turns host-level flash operations (sector erase, page program, status read) into the required command series. Each write is preceded by a WRITE ENABLE and followed by status polling until the write-in-progress bit clears. Sits between the host/control logic and the single `spi_cmd` instance, owning its trigger/frame/count inputs.

## Interface

- `POLL_GAP`, 64, idle clocks between successive RDSR polls (≥1)
- `POLL_MAX`, 65535, max RDSR polls after erase/program before timeout (16-bit)
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `op_valid`  in  1  operation request
- `op_ready`  out  1  high in IDLE; accept when `op_valid && op_ready`
- `op_code`  in  2  0 = ERASE (0xD8), 1 = PROGRAM (0x02), 2 = READ_STATUS (0x05), 3 = illegal
- `op_addr`  in  24  flash byte address (ERASE/PROGRAM)
- `op_len`  in  9  PROGRAM byte count, 1..256
- `quad`  in  1  IO mode for all commands of this op; sampled at accept
- `wr_valid` / `wr_ready`  in / out  1  page byte stream handshake
- `wr_data`  in  8  page byte, first byte first
- `done`  out  1  one-cycle completion pulse
- `err`  out  1  valid with `done`, held until next accept
- `status`  out  8  last status register read, held
- `spi_trigger`  out  1  to `spi_cmd.trigger`
- `spi_busy`  in  1  from `spi_cmd.busy`
- `spi_data_in_count`  out  9  frame length in bytes
- `spi_data_out_count`  out  1  1 = read one byte after frame
- `spi_data_in`  out  2080  frame, right-aligned: first byte at `[8N-1 -: 8]`, last byte at `[7:0]`
- `spi_data_out`  in  8  read byte from `spi_cmd`
- `spi_quad`  out  1  registered copy of `quad`

## Operation

- States: IDLE, LOAD, WREN, MAIN, GAP, POLL, FINISH.
- WREN, MAIN and POLL each run a command slot of three phases:
  - ISSUE: `spi_trigger=1` only while `spi_busy==0`.
  - START: wait for `spi_busy==1`.
  - END: wait for `spi_busy==0`. For a read command, capture `spi_data_out` into `status` in this cycle.
- Accept actions:
  - Latch `quad`.
  - Clear `err`.
  - Load frame register with `{CMD, op_addr}` in bits `[31:0]`.
- Illegal `op_code`, or PROGRAM with `op_len==0` or `op_len>256`: go directly to FINISH with `err=1`. No trigger is issued.
- PROGRAM:
  - LOAD: `wr_ready=1`. Each accepted byte does `frame <= {frame, wr_data}`. After `op_len` bytes, go to WREN.
  - Then MAIN with count `4+op_len`, out 0.
- ERASE: WREN, then MAIN with count 4, out 0.
- After MAIN (ERASE/PROGRAM):
  - GAP counts `POLL_GAP` clocks, then POLL.
  - POLL sends RDSR: count 1, out 1, frame `0x05`.
  - If `status[0]==1` and polls < `POLL_MAX`: go to GAP.
  - If `status[0]==0`: FINISH, `err=0`.
  - If `POLL_MAX` polls are exhausted with `status[0]` still 1: FINISH, `err=1`.
- READ_STATUS: one POLL slot, then FINISH. No WREN, no GAP.
- `spi_data_in` mux by state:
  - WREN: `0x06` in `[7:0]`.
  - POLL: `0x05` in `[7:0]`.
  - Otherwise: the frame register.
  - Stable from ISSUE through END.
- FINISH: `done=1` for one cycle, then IDLE.

## Timing

- Reset values:
  - `op_ready=1`, `wr_ready=0`, `done=0`, `err=0`, `status=0x00`.
  - `spi_trigger=0`, `spi_data_in_count=0`, `spi_data_out_count=0`, `spi_quad=0`, frame = 0.
- Reset mid-operation aborts to IDLE. `spi_cmd` shares the reset.
- `spi_busy` is high while `spi_cmd` is in reset; ISSUE stalls until it drops.
- Trigger is never asserted in two consecutive cycles.
- Illegal op: `done` pulses two cycles after accept (accept → FINISH).
- `op_valid` is ignored outside IDLE. `wr_valid` is ignored outside LOAD.
- Poll counter is 16-bit and cleared at MAIN END.

## Structure

- Shared package `spi_flash_pkg`:
  - Opcodes: `CMD_WREN 8'h06`, `CMD_RDSR 8'h05`, `CMD_PP 8'h02`, `CMD_SE 8'hD8`.
  - `op_code` encodings.
  - `FRAME_W = 2080`, `MAX_PAGE = 256`.
- One sub-module, `spi_cmd_issue`: the ISSUE/START/END slot handshake with start/complete strobes.

## Test plan

- READ_STATUS, model SR=0x42 → one trigger with count 1, out 1, `[7:0]=0x05`; then `done`, `status=0x42`, `err=0`.
- ERASE addr 0x012345, WIP=1 for 3 polls → frames in order:
  - `0x06`
  - count 4, `[31:0]=0xD8012345`, out 0
  - 4 RDSR, with gaps ≥ `POLL_GAP`
  - then `done`, `err=0`.
- PROGRAM addr 0x000100, len 3, bytes AA BB CC → count 7, `[55:0]=0x02000100AABBCC`. Len 256 → count 260, byte0 at `[2047:2040]`, byte255 at `[7:0]`.
- `op_code=3`, and PROGRAM with `op_len=0` → `done` with `err=1`, zero triggers, `wr_ready` never high.
- `POLL_MAX=4`, WIP stuck at 1 → exactly 4 RDSR, then `done` with `err=1`, `status[0]=1`.
- Reset asserted during GAP → all outputs at reset values next cycle; a following READ_STATUS completes normally.
